// File: rtl/led_frame_arbiter.sv
// Arbitrates the WS2812 panel among roll, snake and gesture frame sources, snapshots one
// index vector per frame and enforces the latch gap. Optional LED_ARB_ROUND_ROBIN_EN selects round-robin.
module led_frame_arbiter #(
   parameter int unsigned CLK_FREQ    = 50_000_000,
   parameter int unsigned RESET_US    = 300,
   parameter int unsigned FRAME_W     = 48,
   parameter int unsigned HOLD_FRAMES = 4
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic [2:0]         req,
   input  logic [FRAME_W-1:0] data0,
   input  logic [FRAME_W-1:0] data1,
   input  logic [FRAME_W-1:0] data2,
   input  logic               frame_done,
   output logic               frame_start,
   output logic [FRAME_W-1:0] frame_data,
   output logic [2:0]         grant,
   output logic               busy
);

   localparam int unsigned GAP_CYC = CLK_FREQ / 1_000_000 * RESET_US;
   localparam int unsigned GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
   localparam int unsigned HOLD_W  = 8;
   localparam logic [GAP_W-1:0]  GAP_LOAD = GAP_W'(GAP_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(HOLD_FRAMES);

   typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_t;

   state_t             r_state, w_state_nxt;
   logic [2:0]         r_grant, w_grant_nxt;
   logic [FRAME_W-1:0] r_data, w_data_nxt;
   logic               r_start, w_start_nxt;
   logic               r_busy, w_busy_nxt;
   logic [HOLD_W-1:0]  r_hold, w_hold_nxt;
   logic [GAP_W-1:0]   r_gap, w_gap_nxt;

   logic [2:0]         w_fresh;
   logic               w_keep;
   logic [2:0]         w_arb_grant;
   logic [HOLD_W-1:0]  w_arb_hold;
   logic [FRAME_W-1:0] w_arb_data;
   logic               w_launch;

`ifdef LED_ARB_ROUND_ROBIN_EN
   logic [1:0] r_ptr, w_ptr_nxt, w_fresh_idx;

   // Round-robin search starting just after the last fresh winner.
   always_comb begin
      logic [1:0] v_idx;
      w_fresh     = '0;
      w_fresh_idx = r_ptr;
      v_idx       = r_ptr;
      for (int k = 1; k <= 3; k++) begin
         v_idx = 2'((32'(r_ptr) + 32'(k)) % 3);
         if ((w_fresh == 3'b000) && req[v_idx]) begin
            w_fresh[v_idx] = 1'b1;
            w_fresh_idx    = v_idx;
         end
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) r_ptr <= 2'd2;
      else            r_ptr <= w_ptr_nxt;
   end

   always_comb begin
      w_ptr_nxt = r_ptr;
      if (w_launch && !w_keep) w_ptr_nxt = w_fresh_idx;
   end
`else
   always_comb begin
      w_fresh = 3'b000;
      if (req[2])      w_fresh = 3'b100;
      else if (req[1]) w_fresh = 3'b010;
      else if (req[0]) w_fresh = 3'b001;
   end
`endif

   // Hold rule: the current owner keeps the panel until it has had HOLD_FRAMES frames.
   always_comb begin
      w_keep      = (|(req & r_grant)) && (r_hold < HOLD_MAX);
      w_arb_grant = w_keep ? r_grant : w_fresh;
      w_arb_hold  = w_keep ? (r_hold + HOLD_W'(1)) : HOLD_W'(1);
      case (w_arb_grant)
         3'b001:  w_arb_data = data0;
         3'b010:  w_arb_data = data1;
         3'b100:  w_arb_data = data2;
         default: w_arb_data = '0;
      endcase
   end

   always_comb begin
      w_state_nxt = r_state;
      w_grant_nxt = r_grant;
      w_data_nxt  = r_data;
      w_start_nxt = 1'b0;
      w_busy_nxt  = r_busy;
      w_hold_nxt  = r_hold;
      w_gap_nxt   = r_gap;
      w_launch    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (|req) w_launch = 1'b1;
         end
         ST_SEND: begin
            // A done pulse coinciding with our own start pulse is stale.
            if (frame_done && !r_start) begin
               w_state_nxt = ST_GAP;
               w_gap_nxt   = GAP_LOAD;
            end
         end
         ST_GAP: begin
            if (r_gap != '0) begin
               w_gap_nxt = r_gap - GAP_W'(1);
            end else if (|req) begin
               w_launch = 1'b1;
            end else begin
               w_state_nxt = ST_IDLE;
               w_grant_nxt = 3'b000;
               w_hold_nxt  = '0;
               w_busy_nxt  = 1'b0;
            end
         end
         default: w_state_nxt = ST_IDLE;
      endcase
      if (w_launch) begin
         w_state_nxt = ST_SEND;
         w_grant_nxt = w_arb_grant;
         w_data_nxt  = w_arb_data;
         w_hold_nxt  = w_arb_hold;
         w_start_nxt = 1'b1;
         w_busy_nxt  = 1'b1;
      end
   end

   always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         r_state <= ST_IDLE;
         r_grant <= '0;
         r_data  <= '0;
         r_start <= 1'b0;
         r_busy  <= 1'b0;
         r_hold  <= '0;
         r_gap   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_grant <= w_grant_nxt;
         r_data  <= w_data_nxt;
         r_start <= w_start_nxt;
         r_busy  <= w_busy_nxt;
         r_hold  <= w_hold_nxt;
         r_gap   <= w_gap_nxt;
      end
   end

   assign frame_start = r_start;
   assign frame_data  = r_data;
   assign grant       = r_grant;
   assign busy        = r_busy;

endmodule

// File: tb/tb_led_frame_arbiter.sv
// Directed bench for led_frame_arbiter: GAP_CYC=100, HOLD_FRAMES=2, serializer answers 50 cycles after start.
module tb_led_frame_arbiter;

   localparam int unsigned FW = 48;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [2:0]    req;
   logic [FW-1:0] data0, data1, data2;
   logic          frame_done;
   logic          frame_start;
   logic [FW-1:0] frame_data;
   logic [2:0]    grant;
   logic          busy;
   logic          spur;

   int cyc = 0;
   int ser_cnt;
   int total = 0;
   int bad = 0;
   int t0, t1, t2, t3;

   led_frame_arbiter #(
      .CLK_FREQ(50_000_000), .RESET_US(2), .FRAME_W(FW), .HOLD_FRAMES(2)
   ) dut (
      .sys_clk(clk), .sys_rst_n(rst_n), .req(req),
      .data0(data0), .data1(data1), .data2(data2),
      .frame_done(frame_done), .frame_start(frame_start),
      .frame_data(frame_data), .grant(grant), .busy(busy)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Serializer model: done pulse in the 50th cycle after the start cycle.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n)           ser_cnt <= 0;
      else if (frame_start) ser_cnt <= 50;
      else if (ser_cnt > 0) ser_cnt <= ser_cnt - 1;
   end
   assign frame_done = (ser_cnt == 1) | spur;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_start(input string tag, output int t);
      int k;
      k = 0;
      @(negedge clk);
      while (frame_start !== 1'b1 && k < 400) begin
         @(negedge clk);
         k++;
      end
      total++;
      assert (k < 400) else begin
         bad++;
         $error("FAIL %s timeout observed=%0d expected<400", tag, k);
      end
      t = cyc;
   endtask

   initial begin
      logic [2:0] exp_g [7];
`ifdef LED_ARB_ROUND_ROBIN_EN
      exp_g = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001};
`else
      exp_g = '{3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100, 3'b100};
`endif
      rst_n = 1'b0; req = 3'b000; spur = 1'b0;
      data0 = '0; data1 = '0; data2 = '0;
      tick(3);
      chk("rst_grant", 64'(grant), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_data", 64'(frame_data), 64'd0);
      chk("rst_start", 64'(frame_start), 64'd0);
      rst_n = 1'b1;
      tick(5);
      chk("idle_no_start", 64'(frame_start), 64'd0);

      // Single requester, then snake joins during the first frame.
      data0 = 48'h0123456789AB; data1 = 48'hAAAAAAAAAAAA; req = 3'b001;
      tick(1);
      t0 = cyc;
      chk("f1_start", 64'(frame_start), 64'd1);
      chk("f1_grant", 64'(grant), 64'b001);
      chk("f1_data", 64'(frame_data), 64'h0123456789AB);
      chk("f1_busy", 64'(busy), 64'd1);
      tick(1);
      chk("f1_width", 64'(frame_start), 64'd0);
      req = 3'b011;
      wait_start("f2_wait", t1);
      chk("f2_spacing", 64'(t1 - t0), 64'd151);
      chk("f2_grant_hold", 64'(grant), 64'b001);
      wait_start("f3_wait", t2);
      chk("f3_spacing", 64'(t2 - t1), 64'd151);
      chk("f3_grant", 64'(grant), 64'b010);
      chk("f3_data", 64'(frame_data), 64'hAAAAAAAAAAAA);

      // Data isolation mid-frame.
      tick(5);
      data1 = 48'h555555555555;
      tick(10);
      chk("iso_data", 64'(frame_data), 64'hAAAAAAAAAAAA);
      chk("iso_grant", 64'(grant), 64'b010);
      wait_start("f4_wait", t3);
      chk("f4_data", 64'(frame_data), 64'h555555555555);
      chk("f4_grant", 64'(grant), 64'b010);

      // Drop to idle: request released during SEND.
      tick(10);
      req = 3'b000;
      tick(140);
      chk("gap_end_busy", 64'(busy), 64'd1);
      chk("gap_end_grant", 64'(grant), 64'b010);
      tick(1);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_grant", 64'(grant), 64'd0);
      chk("idle_start", 64'(frame_start), 64'd0);

      // Spurious done in IDLE.
      spur = 1'b1;
      tick(1);
      spur = 1'b0;
      tick(3);
      chk("spur_idle_busy", 64'(busy), 64'd0);
      chk("spur_idle_start", 64'(frame_start), 64'd0);

      // Gesture frame with done pulses coinciding with start and inside GAP.
      data2 = 48'hFEDCBA987654; req = 3'b100;
      tick(1);
      chk("f5_start", 64'(frame_start), 64'd1);
      chk("f5_grant", 64'(grant), 64'b100);
      chk("f5_data", 64'(frame_data), 64'hFEDCBA987654);
      spur = 1'b1;
      tick(1);
      spur = 1'b0; req = 3'b000;
      tick(58);
      spur = 1'b1;
      tick(1);
      spur = 1'b0;
      tick(90);
      chk("f5_gap_busy", 64'(busy), 64'd1);
      tick(1);
      chk("f5_idle_busy", 64'(busy), 64'd0);
      chk("f5_idle_grant", 64'(grant), 64'd0);

      // Reset mid-frame.
      req = 3'b001;
      tick(1);
      chk("f6_start", 64'(frame_start), 64'd1);
      tick(20);
      req = 3'b000;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_grant", 64'(grant), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_data", 64'(frame_data), 64'd0);
      tick(3);
      rst_n = 1'b1;
      tick(5);
      chk("post_rst_start", 64'(frame_start), 64'd0);
      chk("post_rst_busy", 64'(busy), 64'd0);
      req = 3'b001;
      tick(1);
      chk("post_rst_f_start", 64'(frame_start), 64'd1);
      chk("post_rst_f_grant", 64'(grant), 64'b001);

      // All three requesting from a fresh reset.
      req = 3'b000;
      rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(2);
      req = 3'b111;
      for (int i = 0; i < 7; i++) begin
         if (i == 0) begin
            tick(1);
            chk("all_f0_start", 64'(frame_start), 64'd1);
         end else begin
            wait_start("all_wait", t0);
         end
         chk($sformatf("all_grant%0d", i), 64'(grant), 64'(exp_g[i]));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
